// File: rtl/quadrature_input_filter.sv
// Encoder front end: synchronises and glitch-filters A/B/I, then decodes
// quadrature transitions into Step/Dir, index pulses and illegal-jump errors.
module quadrature_input_filter #(
  parameter int FILTER_CYCLES = 4,
  parameter int PRESCALE      = 1,
  parameter int ERR_WIDTH     = 8
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 A,
  input  logic                 B,
  input  logic                 I,
  input  logic                 ClearError,
  output logic                 Step,
  output logic                 Dir,
  output logic                 IndexPulse,
  output logic                 AF,
  output logic                 BF,
  output logic                 IF,
  output logic                 Error,
  output logic [ERR_WIDTH-1:0] ErrorCount,
  output logic                 Ready
);

  localparam int CW = $clog2(FILTER_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FILTER_CYCLES);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  // Position along the CW cycle 00->01->11->10 for an {A,B} pair.
  function automatic logic [1:0] quad_phase(input logic [1:0] ab);
    return {ab[1], ab[1] ^ ab[0]};
  endfunction

  function automatic logic [ERR_WIDTH-1:0] sat_inc(input logic [ERR_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic tick;

  generate
    if (PRESCALE > 1) begin : g_prescale
      localparam int PW = $clog2(PRESCALE);
      localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
      logic [PW-1:0] pre_q, pre_d;
      always_comb pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
      always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) pre_q <= '0;
        else       pre_q <= pre_d;
      end
      assign tick = (pre_q == PRE_LAST);
    end else begin : g_no_prescale
      assign tick = 1'b1;
    end
  endgenerate

  // Channel index: 0 = A, 1 = B, 2 = I.
  logic [2:0]         s1_q, s1_d, s2_q, s2_d, filt_q, filt_d;
  logic [2:0][CW-1:0] cnt_q, cnt_d, stab_q, stab_d;
  logic [2:0]         settled_q, settled_d, settled_now, accept;
  logic [1:0]         fill_q, fill_d, prev_ab_q, prev_ab_d, phase_diff;
  state_t             state_q, state_d;
  logic               prev_i_q, prev_i_d, illegal;
  logic               step_q, step_d, dir_q, dir_d, index_q, index_d;
  logic               error_q, error_d, ready_q, ready_d;
  logic [ERR_WIDTH-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    for (int c = 0; c < 3; c++) settled_now[c] = settled_q[c] | (stab_q[c] == CNT_FULL);
  end

  always_comb begin
    s1_d       = {I, B, A};
    s2_d       = s1_q;
    filt_d     = filt_q;
    cnt_d      = cnt_q;
    stab_d     = stab_q;
    settled_d  = settled_q;
    fill_d     = fill_q;
    state_d    = state_q;
    prev_ab_d  = prev_ab_q;
    prev_i_d   = prev_i_q;
    step_d     = 1'b0;
    index_d    = 1'b0;
    dir_d      = dir_q;
    error_d    = error_q;
    err_cnt_d  = err_cnt_q;
    ready_d    = ready_q;
    accept     = '0;
    illegal    = 1'b0;
    phase_diff = '0;

    for (int c = 0; c < 3; c++) begin
      if (tick) begin
        if (s2_q[c] == filt_q[c]) begin
          cnt_d[c] = '0;
        end else if (cnt_q[c] == CNT_LAST) begin
          filt_d[c] = s2_q[c];
          cnt_d[c]  = '0;
          accept[c] = 1'b1;
        end else begin
          cnt_d[c] = cnt_q[c] + 1'b1;
        end
      end
    end

    case (state_q)
      ST_INIT: begin
        // Stability is only counted once the synchroniser holds real samples.
        if (fill_q != 2'd2) fill_d = fill_q + 2'd1;
        for (int c = 0; c < 3; c++) begin
          if (accept[c]) settled_d[c] = 1'b1;
          if (tick && fill_q == 2'd2) begin
            if (s2_q[c] != filt_q[c])       stab_d[c] = '0;
            else if (stab_q[c] != CNT_FULL) stab_d[c] = stab_q[c] + 1'b1;
          end
        end
        if (&settled_now) begin
          state_d   = ST_RUN;
          ready_d   = 1'b1;
          prev_ab_d = {filt_q[0], filt_q[1]};
          prev_i_d  = filt_q[2];
        end
      end
      default: begin
        prev_ab_d  = {filt_q[0], filt_q[1]};
        prev_i_d   = filt_q[2];
        index_d    = filt_q[2] & ~prev_i_q;
        phase_diff = quad_phase({filt_q[0], filt_q[1]}) - quad_phase(prev_ab_q);
        case (phase_diff)
          2'd1:    begin step_d = 1'b1; dir_d = 1'b1; end
          2'd3:    begin step_d = 1'b1; dir_d = 1'b0; end
          2'd2:    illegal = 1'b1;
          default: ;
        endcase
      end
    endcase

    // A clear coinciding with a new illegal jump still records that jump.
    if (ClearError) begin
      error_d   = illegal;
      err_cnt_d = illegal ? ERR_WIDTH'(1) : '0;
    end else if (illegal) begin
      error_d   = 1'b1;
      err_cnt_d = sat_inc(err_cnt_q);
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      s1_q      <= '0;
      s2_q      <= '0;
      filt_q    <= '0;
      cnt_q     <= '0;
      stab_q    <= '0;
      settled_q <= '0;
      fill_q    <= '0;
      state_q   <= ST_INIT;
      prev_ab_q <= '0;
      prev_i_q  <= 1'b0;
      step_q    <= 1'b0;
      dir_q     <= 1'b1;
      index_q   <= 1'b0;
      error_q   <= 1'b0;
      err_cnt_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      filt_q    <= filt_d;
      cnt_q     <= cnt_d;
      stab_q    <= stab_d;
      settled_q <= settled_d;
      fill_q    <= fill_d;
      state_q   <= state_d;
      prev_ab_q <= prev_ab_d;
      prev_i_q  <= prev_i_d;
      step_q    <= step_d;
      dir_q     <= dir_d;
      index_q   <= index_d;
      error_q   <= error_d;
      err_cnt_q <= err_cnt_d;
      ready_q   <= ready_d;
    end
  end

  assign Step       = step_q;
  assign Dir        = dir_q;
  assign IndexPulse = index_q;
  assign AF         = filt_q[0];
  assign BF         = filt_q[1];
  assign IF         = filt_q[2];
  assign Error      = error_q;
  assign ErrorCount = err_cnt_q;
  assign Ready      = ready_q;

endmodule

// File: tb/tb_quadrature_input_filter.sv
// Bench for quadrature_input_filter: directed scenarios plus random A/B/I
// activity, every cycle compared against a sliding-window reference model.
module tb_quadrature_input_filter;

  localparam int FC   = 4;
  localparam int PS   = 1;
  localparam int EW   = 2;
  localparam int MAXE = 8192;

  logic Clock = 1'b0;
  logic Reset, A, B, I, ClearError;
  logic Step, Dir, IndexPulse, AF, BF, IF, Error, Ready;
  logic [EW-1:0] ErrorCount;

  int vectors = 0;
  int miscompares = 0;

  logic [2:0] hist [MAXE];
  logic [2:0] fh   [MAXE];
  int         e;
  logic [2:0] m_f;
  logic       m_dir, m_step, m_idx, m_err, m_ready;
  logic [EW-1:0] m_cnt;
  logic [1:0] qseq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  always #5 Clock = ~Clock;

  quadrature_input_filter #(
    .FILTER_CYCLES(FC), .PRESCALE(PS), .ERR_WIDTH(EW)
  ) dut (
    .Clock(Clock), .Reset(Reset), .A(A), .B(B), .I(I), .ClearError(ClearError),
    .Step(Step), .Dir(Dir), .IndexPulse(IndexPulse), .AF(AF), .BF(BF), .IF(IF),
    .Error(Error), .ErrorCount(ErrorCount), .Ready(Ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int qpos(input logic [1:0] ab);
    for (int k = 0; k < 4; k++) if (qseq[k] == ab) return k;
    return 0;
  endfunction

  // Raw value seen at edge k; before the first edge the synchroniser holds 0.
  function automatic logic samp(input int k, input int c);
    return (k < 1) ? 1'b0 : hist[k][c];
  endfunction

  task automatic run_cycle();
    logic v, win_ok, ill;
    logic [1:0] ab_new, ab_old;
    int d;
    @(posedge Clock);
    e++;
    if (e >= MAXE) begin
      $display("FAIL model_history e=%0d limit=%0d", e, MAXE);
      $fatal(1);
    end
    hist[e] = {I, B, A};
    // A filtered level follows the synchronised input once the last FC samples agree.
    for (int c = 0; c < 3; c++) begin
      v = samp(e - 2, c);
      win_ok = 1'b1;
      for (int k = e - FC - 1; k <= e - 2; k++) if (samp(k, c) != v) win_ok = 1'b0;
      if (win_ok && v != m_f[c]) m_f[c] = v;
    end
    fh[e] = m_f;
    m_step = 1'b0;
    m_idx  = 1'b0;
    ill    = 1'b0;
    if (e >= 8) begin
      ab_new = {fh[e-1][0], fh[e-1][1]};
      ab_old = {fh[e-2][0], fh[e-2][1]};
      d = (qpos(ab_new) - qpos(ab_old) + 4) % 4;
      if (d == 1)      begin m_step = 1'b1; m_dir = 1'b1; end
      else if (d == 3) begin m_step = 1'b1; m_dir = 1'b0; end
      else if (d == 2) ill = 1'b1;
      m_idx = fh[e-1][2] & ~fh[e-2][2];
    end
    if (ClearError) begin
      m_err = ill;
      m_cnt = ill ? EW'(1) : '0;
    end else if (ill) begin
      m_err = 1'b1;
      if (m_cnt != '1) m_cnt++;
    end
    m_ready = (e >= 7);
    #1;
    check("step",   Step,       m_step);
    check("dir",    Dir,        m_dir);
    check("index",  IndexPulse, m_idx);
    check("af",     AF,         m_f[0]);
    check("bf",     BF,         m_f[1]);
    check("if",     IF,         m_f[2]);
    check("error",  Error,      m_err);
    check("errcnt", ErrorCount, m_cnt);
    check("ready",  Ready,      m_ready);
  endtask

  task automatic hold(input int n, output int step_lat, output int idx_lat, output int nsteps);
    step_lat = -1;
    idx_lat  = -1;
    nsteps   = 0;
    for (int i = 1; i <= n; i++) begin
      run_cycle();
      if (Step === 1'b1) begin
        nsteps++;
        if (step_lat < 0) step_lat = i;
      end
      if (IndexPulse === 1'b1 && idx_lat < 0) idx_lat = i;
    end
  endtask

  task automatic apply_reset();
    Reset = 1'b1;
    #1;
    check("rst_step",   Step,       1'b0);
    check("rst_dir",    Dir,        1'b1);
    check("rst_index",  IndexPulse, 1'b0);
    check("rst_af",     AF,         1'b0);
    check("rst_bf",     BF,         1'b0);
    check("rst_if",     IF,         1'b0);
    check("rst_error",  Error,      1'b0);
    check("rst_errcnt", ErrorCount, '0);
    check("rst_ready",  Ready,      1'b0);
    @(posedge Clock);
    #1;
    @(negedge Clock);
    Reset   = 1'b0;
    e       = 0;
    m_f     = '0;
    fh[0]   = '0;
    m_dir   = 1'b1;
    m_err   = 1'b0;
    m_cnt   = '0;
    m_step  = 1'b0;
    m_idx   = 1'b0;
    m_ready = 1'b0;
  endtask

  initial begin
    int sl, il, ns;
    int ha, hi, r;
    A = 1'b0; B = 1'b0; I = 1'b0; ClearError = 1'b0;
    apply_reset();

    // Quiet start-up: Ready after 7 clocks, nothing else.
    hold(20, sl, il, ns);
    check("init_no_step",  sl,    -1);
    check("init_no_index", il,    -1);
    check("init_ready",    Ready, 1'b1);

    for (int k = 1; k <= 4; k++) begin
      {A, B} = qseq[k % 4];
      hold(10, sl, il, ns);
      check("cw_latency", sl,  7);
      check("cw_steps",   ns,  1);
      check("cw_dir",     Dir, 1'b1);
    end
    for (int k = 3; k >= 0; k--) begin
      {A, B} = qseq[k];
      hold(10, sl, il, ns);
      check("ccw_latency", sl,  7);
      check("ccw_steps",   ns,  1);
      check("ccw_dir",     Dir, 1'b0);
    end

    A = 1'b1;
    hold(3, sl, il, ns);
    A = 1'b0;
    hold(10, sl, il, ns);
    check("glitch3_steps", ns, 0);
    check("glitch3_af",    AF, 1'b0);

    A = 1'b1;
    hold(4, sl, il, ns);
    check("glitch4_early", ns, 0);
    A = 1'b0;
    hold(12, sl, il, ns);
    check("glitch4_first", sl, 3);
    check("glitch4_steps", ns, 2);

    {A, B} = 2'b11;
    hold(10, sl, il, ns);
    check("illegal_steps",  ns,         0);
    check("illegal_error",  Error,      1'b1);
    check("illegal_errcnt", ErrorCount, 2'd1);

    {A, B} = 2'b00;
    hold(6, sl, il, ns);
    ClearError = 1'b1;
    hold(1, sl, il, ns);
    ClearError = 1'b0;
    check("clr_same_error",  Error,      1'b1);
    check("clr_same_errcnt", ErrorCount, 2'd1);
    hold(4, sl, il, ns);

    I = 1'b1;
    hold(10, sl, il, ns);
    check("index_latency", il, 7);
    check("index_nostep",  ns, 0);
    I = 1'b0;
    hold(10, sl, il, ns);
    check("index_fall", il, -1);

    for (int j = 0; j < 5; j++) begin
      {A, B} = (j % 2 == 0) ? 2'b11 : 2'b00;
      hold(10, sl, il, ns);
    end
    check("sat_errcnt", ErrorCount, 2'd3);
    ClearError = 1'b1;
    hold(1, sl, il, ns);
    ClearError = 1'b0;
    check("clear_error",  Error,      1'b0);
    check("clear_errcnt", ErrorCount, 2'd0);

    // Reset while the A filter counter is part-way through a change.
    {A, B} = 2'b01;
    hold(10, sl, il, ns);
    A = 1'b1;
    hold(4, sl, il, ns);
    #2;
    apply_reset();
    hold(20, sl, il, ns);
    check("post_rst_steps", ns,    0);
    check("post_rst_ready", Ready, 1'b1);
    check("post_rst_af",    AF,    1'b1);

    ha = 0;
    hi = 0;
    for (int n = 0; n < 3000; n++) begin
      if (ha == 0) begin
        r = $urandom_range(0, 9);
        if (r == 0) begin A = ~A; B = ~B; end
        else if (r < 6) A = ~A;
        else B = ~B;
        ha = $urandom_range(1, 12);
      end
      ha--;
      if (hi == 0) begin
        I = ~I;
        hi = $urandom_range(1, 14);
      end
      hi--;
      ClearError = ($urandom_range(0, 19) == 0);
      run_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
